// File: rtl/fir_mac_engine_pkg.sv
// fir_pkg: FIR engine states, default geometry and the shared round/saturate helper.
package fir_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} fir_state_e;
  localparam int FIR_DATA_WIDTH = 16;
  localparam int FIR_COEF_WIDTH = 16;
  localparam int FIR_ADDR_WIDTH = 9;
  localparam int FIR_TAPS = 256;
  localparam int FIR_ACC_WIDTH = 40;
  localparam int FIR_SHIFT = 15;
  localparam int FIR_ACC_MAX = 128;
  // Round half up, arithmetic shift, clamp to a signed dw-bit range; callers truncate to dw.
  function automatic logic signed [FIR_ACC_MAX-1:0] round_sat(input logic signed [FIR_ACC_MAX-1:0] acc, input int shift, input int dw);
    logic signed [FIR_ACC_MAX-1:0] r, hi, lo;
    r = (acc + (FIR_ACC_MAX'(1) <<< (shift - 1))) >>> shift;
    hi = (FIR_ACC_MAX'(1) <<< (dw - 1)) - FIR_ACC_MAX'(1);
    lo = -hi - FIR_ACC_MAX'(1);
    return r > hi ? hi : r < lo ? lo : r;
  endfunction
endpackage

// File: rtl/fir_mac_engine_if.sv
// fir_mac_engine_if: delay-line read port, coefficient ROM port and filtered output stream.
interface fir_mac_engine_if import fir_pkg::*; #(
  parameter int DATA_WIDTH = FIR_DATA_WIDTH,
  parameter int COEF_WIDTH = FIR_COEF_WIDTH,
  parameter int ADDR_WIDTH = FIR_ADDR_WIDTH,
  parameter int TAPS = FIR_TAPS
);
  logic sr_busy;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic signed [DATA_WIDTH-1:0] rd_data;
  logic [$clog2(TAPS)-1:0] coef_addr;
  logic signed [COEF_WIDTH-1:0] coef_data;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic out_valid;
  logic busy;
  logic overrun;
  modport master (
    input sr_busy, rd_data, coef_data,
    output rd_addr, coef_addr, out_data, out_valid, busy, overrun
  );
  modport slave (
    output sr_busy, rd_data, coef_data,
    input rd_addr, coef_addr, out_data, out_valid, busy, overrun
  );
endinterface

// File: rtl/fir_mac_pipe.sv
// fir_mac_pipe: two-stage valid shift, registered signed product and valid-gated accumulator.
module fir_mac_pipe import fir_pkg::*; #(
  parameter int A_WIDTH = FIR_DATA_WIDTH,
  parameter int B_WIDTH = FIR_COEF_WIDTH,
  parameter int ACC_WIDTH = FIR_ACC_WIDTH
) (
  input logic clk,
  input logic rst_n,
  input logic clr,
  input logic in_valid,
  input logic signed [A_WIDTH-1:0] a,
  input logic signed [B_WIDTH-1:0] b,
  output logic signed [ACC_WIDTH-1:0] acc
);
  localparam int PW = A_WIDTH + B_WIDTH;
  logic signed [PW-1:0] prod;
  logic [1:0] vs;
  // vs[0] marks a/b as real tap data (memory latency), vs[1] marks prod.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vs <= '0;
      prod <= '0;
      acc <= '0;
    end else if (clr) begin
      vs <= '0;
      prod <= '0;
      acc <= '0;
    end else begin
      vs <= {vs[0], in_valid};
      prod <= PW'(a) * PW'(b);
      if (vs[1]) acc <= acc + ACC_WIDTH'(prod);
    end
endmodule

// File: rtl/fir_mac_engine.sv
// fir_mac_engine: sweeps the delay line after each committed sample and emits one rounded,
// saturated FIR output per sweep.
module fir_mac_engine import fir_pkg::*; #(
  parameter int DATA_WIDTH = FIR_DATA_WIDTH,
  parameter int COEF_WIDTH = FIR_COEF_WIDTH,
  parameter int ADDR_WIDTH = FIR_ADDR_WIDTH,
  parameter int TAPS = FIR_TAPS,
  parameter int ACC_WIDTH = FIR_ACC_WIDTH,
  parameter int SHIFT = FIR_SHIFT
) (
  input logic clk,
  input logic rst_n,
  fir_mac_engine_if.master bus
);
  localparam int KW = $clog2(TAPS);
  fir_state_e state, state_nx;
  logic [KW-1:0] k, k_nx;
  logic dcnt, dcnt_nx;
  logic sr_q, start;
  logic signed [ACC_WIDTH-1:0] acc;
  assign start = sr_q & ~bus.sr_busy;
  always_comb begin
    state_nx = state;
    k_nx = k;
    dcnt_nx = dcnt;
    case (state)
      IDLE: if (start) begin
        state_nx = ISSUE;
        k_nx = '0;
      end
      ISSUE: begin
        k_nx = k + 1'b1;
        dcnt_nx = 1'b0;
        if (k == KW'(TAPS - 1)) state_nx = DRAIN;
      end
      DRAIN: begin
        dcnt_nx = 1'b1;
        if (dcnt) state_nx = OUT;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      k <= '0;
      dcnt <= 1'b0;
      sr_q <= 1'b0;
      bus.out_data <= '0;
      bus.out_valid <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      state <= state_nx;
      k <= k_nx;
      dcnt <= dcnt_nx;
      sr_q <= bus.sr_busy;
      bus.out_valid <= state == OUT;
      if (state == OUT) bus.out_data <= DATA_WIDTH'(round_sat(FIR_ACC_MAX'(acc), SHIFT, DATA_WIDTH));
      if (start && state != IDLE) bus.overrun <= 1'b1;
    end
  // Tap k=0 is the newest sample, which the delay line keeps at address TAPS.
  assign bus.rd_addr = state == ISSUE ? ADDR_WIDTH'(TAPS) - ADDR_WIDTH'(k) : ADDR_WIDTH'(TAPS);
  assign bus.coef_addr = state == ISSUE ? k : '0;
  assign bus.busy = state != IDLE;
  fir_mac_pipe #(.A_WIDTH(DATA_WIDTH), .B_WIDTH(COEF_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_pipe (
    .clk(clk),
    .rst_n(rst_n),
    .clr(state == IDLE && start),
    .in_valid(state == ISSUE),
    .a(bus.rd_data),
    .b(bus.coef_data),
    .acc(acc)
  );
endmodule

// File: tb/tb_fir_mac_engine.sv
// tb_fir_mac_engine: directed and random sweeps of an 8-tap engine against a sum-of-products model.
module tb_fir_mac_engine;
  localparam int DW = 16, CW = 16, AW = 9, T = 8, AC = 40, SH = 15;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  logic signed [DW-1:0] hist [T];
  logic signed [CW-1:0] coef [T];
  logic signed [DW-1:0] got;
  fir_mac_engine_if #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .ADDR_WIDTH(AW), .TAPS(T)) bus ();
  fir_mac_engine #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .ADDR_WIDTH(AW), .TAPS(T), .ACC_WIDTH(AC), .SHIFT(SH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  // Synchronous-read delay line (address T = newest) and coefficient ROM.
  always @(posedge clk) begin
    bus.rd_data <= (bus.rd_addr >= 1 && bus.rd_addr <= T) ? hist[T - int'(bus.rd_addr)] : 'x;
    bus.coef_data <= coef[bus.coef_addr];
  end

  function automatic logic signed [DW-1:0] model();
    longint s = 0;
    for (int i = 0; i < T; i++) s += longint'(hist[i]) * longint'(coef[i]);
    s = (s + (longint'(1) << (SH - 1))) >>> SH;
    return s > 32767 ? 16'sh7fff : s < -32768 ? 16'sh8000 : DW'(s);
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic commit();
    @(negedge clk);
    bus.sr_busy = 1'b1;
    @(negedge clk);
    bus.sr_busy = 1'b0;
  endtask

  task automatic sweep(input string tag, input int ov_at, output logic signed [DW-1:0] res);
    logic signed [DW-1:0] exp;
    int nv;
    exp = model();
    nv = 0;
    res = 'x;
    commit();
    for (int c = 0; c < T + 8; c++) begin
      @(negedge clk);
      if (c == ov_at) bus.sr_busy = 1'b1;
      if (c == ov_at + 1) bus.sr_busy = 1'b0;
      if (c < T) begin
        chk({tag, ":rd_addr"}, bus.rd_addr, T - c);
        chk({tag, ":coef_addr"}, bus.coef_addr, c);
      end else if (c >= T + 3) chk({tag, ":rd_addr_idle"}, bus.rd_addr, T);
      if (c == 0 || c == T + 2) chk({tag, ":busy_hi"}, bus.busy, 1);
      if (c == T + 3) chk({tag, ":busy_lo"}, bus.busy, 0);
      if (bus.out_valid) begin
        nv++;
        chk({tag, ":latency"}, c, T + 3);
        chk({tag, ":out_data"}, bus.out_data, exp);
        res = bus.out_data;
      end
    end
    chk({tag, ":n_valid"}, nv, 1);
  endtask

  task automatic push(input string tag, input logic signed [DW-1:0] s, output logic signed [DW-1:0] res);
    for (int i = T - 1; i > 0; i--) hist[i] = hist[i - 1];
    hist[0] = s;
    sweep(tag, -1, res);
  endtask

  initial begin
    int nv;
    bus.sr_busy = 1'b0;
    for (int i = 0; i < T; i++) begin
      hist[i] = '0;
      coef[i] = CW'(16'h7fff >> i);
    end
    coef[1] = 16'sh4000;
    repeat (3) @(negedge clk);
    chk("rst:rd_addr", bus.rd_addr, T);
    chk("rst:coef_addr", bus.coef_addr, 0);
    chk("rst:out_data", bus.out_data, 0);
    chk("rst:out_valid", bus.out_valid, 0);
    chk("rst:busy", bus.busy, 0);
    chk("rst:overrun", bus.overrun, 0);
    rst_n = 1'b1;
    // Impulse walks through every tap, then falls off the end.
    push("impulse0", 16'sh4000, got);
    chk("impulse0:const", got, 16'sh4000);
    push("impulse1", 16'sh0000, got);
    chk("impulse1:const", got, 16'sh2000);
    for (int i = 2; i < T; i++) push("impulse_n", 16'sh0000, got);
    push("impulse_gone", 16'sh0000, got);
    chk("impulse_gone:const", got, 0);
    for (int i = 0; i < T; i++) begin
      hist[i] = 16'sh7fff;
      coef[i] = 16'sh7fff;
    end
    sweep("sat_pos", -1, got);
    chk("sat_pos:const", got, 16'sh7fff);
    for (int i = 0; i < T; i++) hist[i] = 16'sh8000;
    sweep("sat_neg", -1, got);
    chk("sat_neg:const", got, -32768);
    for (int i = 0; i < T; i++) begin
      hist[i] = '0;
      coef[i] = '0;
    end
    coef[0] = 16'sh0001;
    hist[0] = 16'sh4000;
    sweep("round_half", -1, got);
    chk("round_half:const", got, 1);
    hist[0] = 16'sh3fff;
    sweep("round_below", -1, got);
    chk("round_below:const", got, 0);
    hist[0] = -16'sh4000;
    sweep("round_neg_half", -1, got);
    chk("round_neg_half:const", got, 0);
    for (int i = 0; i < T; i++) coef[i] = CW'($urandom);
    for (int n = 0; n < 6; n++) push("random", DW'($urandom), got);
    chk("pre_overrun:overrun", bus.overrun, 0);
    for (int i = 0; i < T; i++) coef[i] = CW'($urandom_range(0, 16'h3fff));
    push("overrun", DW'($urandom), got);
    sweep("overrun_sweep", 3, got);
    chk("overrun:flag", bus.overrun, 1);
    // Reset while tap 3 is on the bus; the interrupted sample must never appear.
    commit();
    for (int c = 0; c < 4; c++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst:rd_addr", bus.rd_addr, T);
    chk("midrst:coef_addr", bus.coef_addr, 0);
    chk("midrst:out_data", bus.out_data, 0);
    chk("midrst:out_valid", bus.out_valid, 0);
    chk("midrst:busy", bus.busy, 0);
    chk("midrst:overrun", bus.overrun, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    for (int c = 0; c < T + 8; c++) begin
      @(negedge clk);
      if (bus.out_valid) nv++;
    end
    chk("midrst:no_valid", nv, 0);
    push("after_rst", DW'($urandom), got);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fir_mac_engine.md
# fir_mac_engine

Streaming FIR filter engine that sits directly downstream of the RAM-based sample delay line in the WM8731 audio path. After each new sample is committed to the delay line, it sweeps the delay-line read port across all taps. Each tap is multiplied by a coefficient from an external coefficient ROM and summed. The engine then emits one rounded, saturated filtered sample toward the DAC serializer.

## Interface
Parameters:
- DATA_WIDTH, 16, signed sample width (delay-line word width)
- COEF_WIDTH, 16, signed coefficient width (Q1.15 by default)
- ADDR_WIDTH, 9, delay-line read-address width
- TAPS, 256, number of taps; must equal delay-line STAGE, 2..2^ADDR_WIDTH-1
- ACC_WIDTH, 40, accumulator width; must be ≥ DATA_WIDTH+COEF_WIDTH+clog2(TAPS)
- SHIFT, 15, right shift applied to accumulator before output (≥1)

Ports:
- clk  in  1  system clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- sr_busy  in  1  delay-line write-busy flag; its high→low transition means a new sample is committed
- rd_addr  out  ADDR_WIDTH  delay-line tap address (TAPS = newest sample, 1 = oldest)
- rd_data  in  DATA_WIDTH  delay-line read data, valid 1 cycle after rd_addr
- coef_addr  out  clog2(TAPS)  coefficient index k (tap k=0 is newest)
- coef_data  in  COEF_WIDTH  coefficient, valid 1 cycle after coef_addr
- out_data  out  DATA_WIDTH  filtered sample, signed, held until next result
- out_valid  out  1  one-cycle pulse when out_data updates
- busy  out  1  high while a sweep or drain is in progress
- overrun  out  1  sticky; set if a new sample commits while busy

## Operation
- Reset values: rd_addr=TAPS, coef_addr=0, out_data=0, out_valid=0, busy=0, overrun=0, accumulator=0, state IDLE.
- Start condition: a registered copy of sr_busy is 1 and the current sr_busy is 0 (falling edge).
- FSM states: IDLE → ISSUE → DRAIN → OUT → IDLE.
  - IDLE: rd_addr held at TAPS. On start: clear accumulator, k←0, go to ISSUE.
  - ISSUE: drives coef_addr=k and rd_addr=TAPS−k for k=0..TAPS−1, one tap per cycle. After k=TAPS−1, go to DRAIN.
  - DRAIN: 2 cycles to flush the multiply/accumulate pipeline.
  - OUT: load out_data, pulse out_valid, return to IDLE.
- rd_addr is never 0 and never moves while sr_busy=1. Address 0 is reserved by the delay line.
- Arithmetic:
  - Each product is the full signed DATA_WIDTH+COEF_WIDTH bits, sign-extended to ACC_WIDTH and summed.
  - Result = (acc + 2^(SHIFT−1)) >>> SHIFT (arithmetic shift, round half up).
  - The result is saturated to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
- Start while busy: the start is ignored, overrun←1, and the current sweep completes unaffected. overrun is cleared only by reset.
- A start in the same cycle as the OUT state is also an overrun. A start in IDLE is accepted in the cycle after OUT.
- Reset asserted mid-sweep: all state returns to reset values immediately. No out_valid is produced for the interrupted sample.

## Timing
- E0 = the edge at which the start is detected.
- busy rises after E0 and falls after E(TAPS+3).
- Tap k address is presented after E(k). Data and coefficient are sampled at E(k+1), the product is registered at E(k+2), and it is accumulated at E(k+3).
- out_data and out_valid update at E(TAPS+3). out_valid is high for exactly that one cycle.
- Minimum spacing between accepted starts: TAPS+4 cycles. At 50 MHz with 48 kHz audio the margin is ample.
- Pipeline registers carry a valid bit. The accumulator adds only valid stages, so no product is counted twice.

## Structure
- Package fir_pkg holds:
  - state enum {IDLE, ISSUE, DRAIN, OUT}
  - default parameter constants
  - a saturate/round function shared with other audio blocks
- Sub-module fir_mac_pipe (product register + accumulator + valid shift) with ports clr, in_valid, a, b, acc.
- The top-level fir_mac_engine holds the FSM, address generation, start detect, and output register.

## Test plan
- Impulse, TAPS=8: delay line holds 0x4000 at the newest sample and 0 elsewhere; coefficients 0x7FFF,0x4000,… → out_data=0x4000 (0x4000·0x7FFF>>>15, rounded). Step the impulse through 8 samples; outputs follow the coefficient sequence, and 0 after 8 samples.
- Saturation: all samples 0x7FFF and all coefficients 0x7FFF, TAPS=8 → out_data=0x7FFF. All samples 0x8000 → out_data=0x8000.
- Rounding: one tap with product 0x4000 and SHIFT=15 → 1. Product 0x3FFF → 0. Product −0x4000 → 0.
- Address sweep: monitor rd_addr for TAPS=8 → sequence 8,7,…,1, never 0, held at 8 in IDLE. out_valid occurs exactly TAPS+3 cycles after E0.
- Overrun: second sr_busy falling edge 5 cycles after E0 → overrun=1. Exactly one out_valid, with the correct value for the first sample.
- Reset mid-sweep: rst_n low at k=3 → all outputs return to reset values, no out_valid. The next start produces a correct result.
